// File: rtl/htg_adc_align_pkg.sv
// Shared types and helpers for the multi-core ADC lane aligner.
// Optional build macro used by the top: ADC_ALIGN_MARKER_CHECK_EN.
package htg_adc_align_pkg;

  localparam int SKEW_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ALIGNED = 2'd2,
    ST_ERROR   = 2'd3
  } align_state_e;

  // Index of the lowest set bit of an up-to-8-bit mask (0 when the mask is empty).
  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/htg_adc_align_fifo.sv
// Single-clock per-core word FIFO with synchronous flush. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
// Read data is the word at the head (show-ahead), so a pop consumes o_rdata.
module htg_adc_align_fifo
  import htg_adc_align_pkg::*;
#(
  parameter int WIDTH = 385,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_flush,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_rd = i_rd && !o_empty && !i_flush;
  // A full FIFO still accepts a write when a word leaves in the same cycle.
  assign w_do_wr = i_wr && (!o_full || w_do_rd) && !i_flush;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array, data only, no reset.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/htg_adc_lane_aligner.sv
// Multi-core ADC sample aligner: buffers each core's words, trims each stream
// to its multiframe marker, then releases all enabled cores in lock-step.
// Build macro ADC_ALIGN_MARKER_CHECK_EN adds per-word marker agreement checking
// (lane slip detection); without it err_marker is tied low.
module htg_adc_lane_aligner
  import htg_adc_align_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int SPC         = 32,
  parameter int SAMPLE_BITS = 12,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               arm,
  input  logic [NUM_CORES-1:0]               core_en,
  input  logic [NUM_CORES-1:0]               din_valid,
  input  logic [NUM_CORES-1:0]               din_marker,
  input  logic [NUM_CORES*SPC*SAMPLE_BITS-1:0] din,
  output logic [NUM_CORES*SPC*SAMPLE_BITS-1:0] dout,
  output logic                               dout_valid,
  output logic                               dout_marker,
  output logic [1:0]                         state,
  output logic [SKEW_W-1:0]                  skew,
  output logic [NUM_CORES-1:0]               err_overflow,
  output logic                               err_timeout,
  output logic                               err_marker
);

  localparam int LANE_W = SPC * SAMPLE_BITS;
  localparam int FW     = LANE_W + 1;
  localparam int DW     = NUM_CORES * LANE_W;
  localparam int TMO_W  = $clog2(TIMEOUT) + 1;

  align_state_e           r_state;
  align_state_e           w_state_nxt;
  logic [NUM_CORES-1:0]   r_mask;
  logic [NUM_CORES-1:0]   r_lock;
  logic [SKEW_W-1:0]      r_skew;
  logic [TMO_W-1:0]       r_tmo;
  logic [NUM_CORES-1:0]   r_err_ovf;
  logic                   r_err_tmo;
  logic [DW-1:0]          r_dout;
  logic                   r_dout_valid;
  logic                   r_dout_marker;

  logic                   w_arm_ok;
  logic                   w_active;
  logic                   w_all_locked;
  logic                   w_any_locked;
  logic                   w_flush;
  logic                   w_pop;
  logic                   w_tmo_hit;
  logic                   w_ovf_any;
  logic                   w_mk_bad;
  logic [NUM_CORES-1:0]   w_wr;
  logic [NUM_CORES-1:0]   w_ovf;
  logic [NUM_CORES-1:0]   w_full;
  logic [NUM_CORES-1:0]   w_empty;
  logic [FW-1:0]          w_rdata [NUM_CORES];
  logic [DW-1:0]          w_dout_nxt;
  logic [7:0]             w_mk8;
  logic [2:0]             w_low;

  assign w_arm_ok     = arm && (core_en != '0);
  assign w_active     = (r_state == ST_WAIT) || (r_state == ST_ALIGNED);
  assign w_all_locked = ((r_lock & r_mask) == r_mask);
  assign w_any_locked = ((r_lock & r_mask) != '0);
  assign w_flush      = w_arm_ok || (r_state == ST_IDLE) || (r_state == ST_ERROR);
  assign w_pop        = (r_state == ST_ALIGNED) && !w_arm_ok &&
                        ((~w_empty | ~r_mask) == '1);
  assign w_tmo_hit    = (r_state == ST_WAIT) && !w_all_locked &&
                        (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_ovf_any    = (w_ovf != '0);
  assign w_low        = lowest_set(8'(r_mask));

  // Per-core write qualification: unlocked cores only take their marker word.
  always_comb begin
    w_wr  = '0;
    w_ovf = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_wr[i]  = w_active && !w_arm_ok && r_mask[i] && din_valid[i] &&
                 (r_lock[i] || din_marker[i]);
      w_ovf[i] = w_wr[i] && w_full[i] && !w_pop;
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    htg_adc_align_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_flush (w_flush),
      .i_wr    (w_wr[g]),
      .i_wdata ({din_marker[g], din[g*LANE_W +: LANE_W]}),
      .i_rd    (w_pop & r_mask[g]),
      .o_rdata (w_rdata[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  // Assemble the next output word from the FIFO heads; disabled lanes read 0.
  always_comb begin
    w_dout_nxt = '0;
    w_mk8      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_mk8[i] = w_rdata[i][LANE_W];
      if (r_mask[i]) w_dout_nxt[i*LANE_W +: LANE_W] = w_rdata[i][LANE_W-1:0];
    end
  end

`ifdef ADC_ALIGN_MARKER_CHECK_EN
  logic                 r_err_mk;
  logic [NUM_CORES-1:0] w_mk_en;
  assign w_mk_en    = w_mk8[NUM_CORES-1:0] & r_mask;
  assign w_mk_bad   = w_pop && (w_mk_en != '0) && (w_mk_en != r_mask);
  assign err_marker = r_err_mk;

  // Sticky marker-disagreement flag, cleared by arm.
  always_ff @(posedge clk) begin
    if (!reset_n || w_arm_ok) r_err_mk <= 1'b0;
    else if (w_mk_bad && !w_ovf_any) r_err_mk <= 1'b1;
  end
`else
  assign w_mk_bad   = 1'b0;
  assign err_marker = 1'b0;
`endif

  // Next-state logic: arm wins, then overflow, then timeout, then normal flow.
  always_comb begin
    w_state_nxt = r_state;
    if (w_arm_ok) begin
      w_state_nxt = ST_WAIT;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_ovf_any || w_tmo_hit) w_state_nxt = ST_ERROR;
          else if (w_all_locked)      w_state_nxt = ST_ALIGNED;
        end
        ST_ALIGNED: begin
          if (w_ovf_any || w_mk_bad) w_state_nxt = ST_ERROR;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Locks, skew/timeout counters, sticky errors and the output register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mask        <= '0;
      r_lock        <= '0;
      r_skew        <= '0;
      r_tmo         <= '0;
      r_err_ovf     <= '0;
      r_err_tmo     <= 1'b0;
      r_dout        <= '0;
      r_dout_valid  <= 1'b0;
      r_dout_marker <= 1'b0;
    end else if (w_arm_ok) begin
      r_mask        <= core_en;
      r_lock        <= '0;
      r_skew        <= '0;
      r_tmo         <= '0;
      r_err_ovf     <= '0;
      r_err_tmo     <= 1'b0;
      r_dout_valid  <= 1'b0;
      r_dout_marker <= 1'b0;
    end else begin
      if (r_state == ST_WAIT) begin
        r_lock <= r_lock | w_wr;
        r_tmo  <= r_tmo + TMO_W'(1);
        if (w_any_locked && !w_all_locked && (r_skew != {SKEW_W{1'b1}}))
          r_skew <= r_skew + SKEW_W'(1);
      end
      if (w_ovf_any) r_err_ovf <= r_err_ovf | w_ovf;
      else if (w_tmo_hit) r_err_tmo <= 1'b1;
      r_dout_valid  <= w_pop;
      r_dout_marker <= w_pop && w_mk8[w_low];
      if (w_pop) r_dout <= w_dout_nxt;
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign dout_marker  = r_dout_marker;
  assign state        = r_state;
  assign skew         = r_skew;
  assign err_overflow = r_err_ovf;
  assign err_timeout  = r_err_tmo;

endmodule
